// File: rtl/gcd_result_packer_if.sv
// Handshake bundle between the GCD result FIFO, the packer and the next stage.
// The master side drives the pop strobe, the packed word and the result count.
interface gcd_result_packer_if #(
  parameter int DATA_W = 4,
  parameter int PACK_N = 4
);
  localparam int LANES_W = $clog2(PACK_N + 1);

  logic                       y_rdy;
  logic [DATA_W-1:0]          y_data;
  logic                       y_en;
  logic                       flush;
  logic [DATA_W*PACK_N-1:0]   word;
  logic [LANES_W-1:0]         word_lanes;
  logic                       word_valid;
  logic                       word_ready;
  logic [7:0]                 res_cnt;

  modport master (
    input  y_rdy, y_data, flush, word_ready,
    output y_en, word, word_lanes, word_valid, res_cnt
  );

  modport slave (
    output y_rdy, y_data, flush, word_ready,
    input  y_en, word, word_lanes, word_valid, res_cnt
  );
endinterface

// File: rtl/gcd_result_packer.sv
// Pops GCD results from a first-word-fall-through FIFO and packs PACK_N of them
// (lane 0 first) into one word offered on a valid/ready port; flush emits a partial word.
module gcd_result_packer #(
  parameter int DATA_W = 4,
  parameter int PACK_N = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  gcd_result_packer_if.master bus
);
  localparam int CW = $clog2(PACK_N + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic            word_valid_reg;
  logic [CW-1:0]   word_lanes_reg;
  logic [7:0]      res_cnt_reg;

  logic            pop;
  logic [CW-1:0]   count_next;
  logic            emit;
  logic            accept;

  // Popping is gated by reset so the FIFO is never drained while held in reset.
  assign pop        = rst_ni && (state_reg == FILL) && bus.y_rdy;
  assign count_next = count_reg + {{(CW-1){1'b0}}, pop};
  assign emit       = (state_reg == FILL) &&
                      ((pop && (count_next == CW'(PACK_N))) ||
                       (bus.flush && (count_next != '0)));
  assign accept     = (state_reg == HOLD) && word_valid_reg && bus.word_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= FILL;
      count_reg      <= '0;
      word_valid_reg <= 1'b0;
      word_lanes_reg <= '0;
      res_cnt_reg    <= 8'd0;
    end else begin
      case (state_reg)
        FILL: begin
          if (pop) begin
            count_reg   <= count_next;
            res_cnt_reg <= res_cnt_reg + 8'd1;
          end
          if (emit) begin
            state_reg      <= HOLD;
            word_valid_reg <= 1'b1;
            word_lanes_reg <= count_next;
          end
        end
        HOLD: begin
          if (accept) begin
            state_reg      <= FILL;
            count_reg      <= '0;
            word_valid_reg <= 1'b0;
            word_lanes_reg <= '0;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  // Each lane captures the result that arrives while the count points at it,
  // and is wiped on acceptance so a later partial word carries zero lanes.
  for (genvar gi = 0; gi < PACK_N; gi++) begin : g_lane
    logic [DATA_W-1:0] lane_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lane_reg <= '0;
      end else if (accept) begin
        lane_reg <= '0;
      end else if (pop && (count_reg == CW'(gi))) begin
        lane_reg <= bus.y_data;
      end
    end

    assign bus.word[gi*DATA_W +: DATA_W] = lane_reg;
  end

  assign bus.y_en       = pop;
  assign bus.word_lanes = word_lanes_reg;
  assign bus.word_valid = word_valid_reg;
  assign bus.res_cnt    = res_cnt_reg;
endmodule

// File: tb/tb_gcd_result_packer.sv
// Directed bench for gcd_result_packer: a FIFO/result-list model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_gcd_result_packer;
  localparam int DATA_W = 4;
  localparam int PACK_N = 4;
  localparam int LW     = $clog2(PACK_N + 1);
  localparam int WW     = DATA_W * PACK_N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcd_result_packer_if #(.DATA_W(DATA_W), .PACK_N(PACK_N)) bus ();

  gcd_result_packer #(.DATA_W(DATA_W), .PACK_N(PACK_N)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus-side FIFO contents and drive knobs.
  int   fifo[$];
  logic rst_v   = 1'b0;
  logic gap_v   = 1'b0;
  logic ready_v = 1'b1;

  // Snapshot of DUT outputs taken at the falling edge inside cyc().
  logic          pend;
  logic          s_valid;
  logic [WW-1:0] s_word;
  logic [LW-1:0] s_lanes;
  logic [7:0]    s_cnt;
  logic          s_yen;

  // Model: results gathered into the current word, whether it is on offer, pops since reset.
  int part[$];
  bit m_hold = 1'b0;
  int m_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack_model();
    logic [WW-1:0] w = '0;
    for (int i = 0; i < part.size(); i++) w[i*DATA_W +: DATA_W] = DATA_W'(part[i]);
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_hold = 1'b0;
      part.delete();
      m_cnt = 0;
    end
    chk("y_en", 32'(bus.y_en), 32'(rst_n && !m_hold && bus.y_rdy));
    chk("word_valid", 32'(bus.word_valid), 32'(m_hold));
    if (m_hold) begin
      chk("word", 32'(bus.word), 32'(pack_model()));
      chk("word_lanes", 32'(bus.word_lanes), 32'(part.size()));
    end
    chk("res_cnt", 32'(bus.res_cnt), 32'(m_cnt % 256));
    if (rst_n) begin
      if (m_hold) begin
        if (bus.word_ready) begin
          m_hold = 1'b0;
          part.delete();
        end
      end else begin
        if (bus.y_rdy) begin
          part.push_back(int'(bus.y_data));
          m_cnt++;
        end
        if (part.size() == PACK_N || (bus.flush && part.size() > 0)) m_hold = 1'b1;
      end
    end
  end

  // One clock: snapshot outputs, then after the edge retire a pop and drive the next inputs.
  task automatic cyc(input logic fl = 1'b0);
    @(negedge clk);
    pend    = bus.y_en;
    s_valid = bus.word_valid;
    s_word  = bus.word;
    s_lanes = bus.word_lanes;
    s_cnt   = bus.res_cnt;
    s_yen   = bus.y_en;
    @(posedge clk);
    #2;
    if (pend) void'(fifo.pop_front());
    rst_n          = rst_v;
    bus.y_rdy      = (fifo.size() > 0) && !gap_v;
    bus.y_data     = (fifo.size() > 0) ? DATA_W'(fifo[0]) : '0;
    bus.flush      = fl;
    bus.word_ready = ready_v;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!s_valid && n < 50);
    if (!s_valid) begin
      total++;
      bad++;
      $display("FAIL %s timeout actual=no_valid required=valid", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.y_rdy      = 1'b0;
    bus.y_data     = '0;
    bus.flush      = 1'b0;
    bus.word_ready = 1'b1;

    // Reset state, with a non-empty FIFO to show no pop happens in reset.
    fifo.push_back(7);
    repeat (3) cyc();
    chk("rst_word", 32'(s_word), 32'h0);
    chk("rst_lanes", 32'(s_lanes), 32'h0);
    chk("rst_valid", 32'(s_valid), 32'h0);
    chk("rst_cnt", 32'(s_cnt), 32'h0);
    chk("rst_yen", 32'(s_yen), 32'h0);
    fifo.delete();
    rst_v = 1'b1;
    cyc();

    // 1: back-to-back 3,5,7,9 with ready high.
    fifo = '{3, 5, 7, 9};
    cyc();
    wait_valid("t1");
    chk("t1_word", 32'(s_word), 32'h9753);
    chk("t1_lanes", 32'(s_lanes), 32'd4);
    chk("t1_cnt", 32'(s_cnt), 32'd4);
    cyc();
    chk("t1_valid_one_cycle", 32'(s_valid), 32'h0);

    // 2: held word with the FIFO still non-empty.
    ready_v = 1'b0;
    fifo = '{3, 5, 7, 9, 1};
    cyc();
    wait_valid("t2");
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t2_word_stable", 32'(s_word), 32'h9753);
      chk("t2_no_pop", 32'(s_yen), 32'h0);
    end
    ready_v = 1'b1;
    cyc();

    // 3: pop 1,2 then flush.
    fifo.push_back(2);
    repeat (5) cyc();
    cyc(1'b1);
    wait_valid("t3");
    chk("t3_word", 32'(s_word), 32'h0021);
    chk("t3_lanes", 32'(s_lanes), 32'd2);

    // 4: flush on an empty word is ignored; flush with the third pop.
    cyc(1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_empty_flush", 32'(s_valid), 32'h0);
    end
    fifo = '{10, 11, 12};
    cyc();
    cyc();
    cyc(1'b1);
    wait_valid("t4");
    chk("t4_word", 32'(s_word), 32'h0CBA);
    chk("t4_lanes", 32'(s_lanes), 32'd3);

    // 5: reset after two pops discards the partial word.
    fifo = '{1, 2};
    repeat (3) cyc();
    fifo = '{4, 3, 2, 1};
    rst_v = 1'b0;
    repeat (3) cyc();
    chk("t5_word", 32'(s_word), 32'h0);
    chk("t5_valid", 32'(s_valid), 32'h0);
    chk("t5_cnt", 32'(s_cnt), 32'h0);
    chk("t5_yen", 32'(s_yen), 32'h0);
    rst_v = 1'b1;
    cyc();
    wait_valid("t5");
    chk("t5_clean_word", 32'(s_word), 32'h1234);
    chk("t5_clean_lanes", 32'(s_lanes), 32'd4);
    chk("t5_clean_cnt", 32'(s_cnt), 32'd4);

    // 6: 253 more results with random gaps, stalls and flushes; count wraps to 1.
    for (int i = 0; i < 253; i++) fifo.push_back(int'($urandom_range(0, 15)));
    begin
      int n = 0;
      while (fifo.size() > 0 && n < 3000) begin
        gap_v   = ($urandom_range(0, 3) == 0);
        ready_v = logic'($urandom_range(0, 1));
        cyc(logic'($urandom_range(0, 15) == 0));
        n++;
      end
      if (fifo.size() > 0) begin
        total++;
        bad++;
        $display("FAIL t6_drain timeout actual=%0d left required=0", fifo.size());
      end
    end
    gap_v   = 1'b0;
    ready_v = 1'b1;
    repeat (3) cyc();
    chk("t6_cnt_wrap", 32'(s_cnt), 32'd1);
    cyc(1'b1);
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
